// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Each channel passes the reference clock
// through in BYPASS and produces a registered divided clock in RUN.
module clk_div_multi #(
  parameter int RATIO_WIDTH = 8,
  parameter int NUM_CH      = 2
) (
  input  logic                          i_ref_clk,
  input  logic                          i_rst,
  input  logic [NUM_CH-1:0]             i_clk_en,
  input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
  input  logic [NUM_CH-1:0]             i_ratio_load,
  output logic [NUM_CH-1:0]             o_div_clk,
  output logic [NUM_CH-1:0]             o_ratio_ack,
  output logic [NUM_CH-1:0]             o_active
);

  typedef enum logic {
    BYPASS = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam logic [RATIO_WIDTH-1:0] ONE = RATIO_WIDTH'(1);
  localparam logic [RATIO_WIDTH-1:0] TWO = RATIO_WIDTH'(2);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_t                 state, state_nxt;
    logic [RATIO_WIDTH-1:0] pend_ratio, pend_ratio_nxt;
    logic [RATIO_WIDTH-1:0] act_ratio, act_ratio_nxt;
    logic [RATIO_WIDTH-1:0] cnt, cnt_nxt;
    logic [RATIO_WIDTH-1:0] ratio_in, new_ratio, half, cnt_inc;
    logic                   pend_flag, pend_flag_nxt;
    logic                   div_q, div_q_nxt;
    logic                   ack_q;
    logic                   apply, at_wrap, new_ok;

    assign ratio_in = i_div_ratio[k*RATIO_WIDTH +: RATIO_WIDTH];
    assign half     = act_ratio >> 1;
    assign cnt_inc  = cnt + ONE;

    always_comb begin
      state_nxt      = state;
      pend_ratio_nxt = pend_ratio;
      pend_flag_nxt  = pend_flag;
      act_ratio_nxt  = act_ratio;
      cnt_nxt        = cnt;
      div_q_nxt      = div_q;

      at_wrap   = (state == RUN) && (cnt == act_ratio - ONE);
      apply     = pend_flag && ((state == BYPASS) || at_wrap);
      // A load landing on the apply point wins over the older pending value.
      new_ratio = i_ratio_load[k] ? ratio_in : pend_ratio;
      new_ok    = (new_ratio >= TWO);

      if (apply) begin
        act_ratio_nxt  = new_ratio;
        pend_ratio_nxt = new_ratio;
        pend_flag_nxt  = 1'b0;
      end else if (i_ratio_load[k]) begin
        pend_ratio_nxt = ratio_in;
        pend_flag_nxt  = 1'b1;
      end

      case (state)
        BYPASS: begin
          if (i_clk_en[k] && (act_ratio >= TWO) && !(apply && !new_ok)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            div_q_nxt = 1'b1;
          end
        end
        RUN: begin
          if (!i_clk_en[k] || (apply && !new_ok)) begin
            state_nxt = BYPASS;
            cnt_nxt   = '0;
            div_q_nxt = 1'b0;
          end else if (apply || at_wrap) begin
            cnt_nxt   = '0;
            div_q_nxt = 1'b1;
          end else begin
            cnt_nxt   = cnt_inc;
            div_q_nxt = (cnt_inc < half);
          end
        end
        default: begin
          state_nxt = BYPASS;
          cnt_nxt   = '0;
          div_q_nxt = 1'b0;
        end
      endcase
    end

    always_ff @(posedge i_ref_clk or negedge i_rst) begin
      if (!i_rst) begin
        state      <= BYPASS;
        pend_ratio <= '0;
        pend_flag  <= 1'b0;
        act_ratio  <= '0;
        cnt        <= '0;
        div_q      <= 1'b0;
        ack_q      <= 1'b0;
      end else begin
        state      <= state_nxt;
        pend_ratio <= pend_ratio_nxt;
        pend_flag  <= pend_flag_nxt;
        act_ratio  <= act_ratio_nxt;
        cnt        <= cnt_nxt;
        div_q      <= div_q_nxt;
        ack_q      <= apply;
      end
    end

    // Only unregistered path: reference clock passes straight through in BYPASS.
    assign o_div_clk[k]   = (state == RUN) ? div_q : i_ref_clk;
    assign o_active[k]    = (state == RUN);
    assign o_ratio_ack[k] = ack_q;
  end

endmodule
